// File: rtl/ysyx_22041207_mul.sv
// Iterative 64x64 -> 64-bit unsigned shift-add multiplier with IDLE/BUSY/DONE handshake.
// Define YSYX_22041207_MUL_RADIX4_EN to retire two multiplier bits per cycle (32 iterations instead of 64).
module ysyx_22041207_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef YSYX_22041207_MUL_RADIX4_EN
    localparam logic [6:0] LAST_ITER = 7'd31;
`else
    localparam logic [6:0] LAST_ITER = 7'd63;
`endif

    logic [1:0]  r_state;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_acc;
    logic [63:0] r_res;
    logic [6:0]  r_cnt;

    logic [63:0] w_addend;
    logic [63:0] w_a_next;
    logic [63:0] w_b_next;
    logic [63:0] w_acc_next;

    // Multiplicand shifts left, multiplier shifts right; bits shifted past 63 are the discarded upper product.
    always_comb begin
`ifdef YSYX_22041207_MUL_RADIX4_EN
        w_addend = (r_b[0] ? r_a : 64'd0) + (r_b[1] ? {r_a[62:0], 1'b0} : 64'd0);
        w_a_next = {r_a[61:0], 2'b00};
        w_b_next = {2'b00, r_b[63:2]};
`else
        w_addend = r_b[0] ? r_a : 64'd0;
        w_a_next = {r_a[62:0], 1'b0};
        w_b_next = {1'b0, r_b[63:1]};
`endif
        w_acc_next = r_acc + w_addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= 64'd0;
            r_b     <= 64'd0;
            r_acc   <= 64'd0;
            r_res   <= 64'd0;
            r_cnt   <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mul_valid && !flush) begin
                        r_a     <= multiplicand;
                        r_b     <= multiplier;
                        r_acc   <= 64'd0;
                        r_cnt   <= 7'd0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_a   <= w_a_next;
                        r_b   <= w_b_next;
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 7'd1;
                        // Result register only loads here so partial sums never reach the outputs.
                        if (r_cnt == LAST_ITER) begin
                            r_res   <= w_acc_next;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_ready = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result_hi = r_res[63:32];
    assign result_lo = r_res[31:0];

endmodule

// File: tb/tb_ysyx_22041207_mul.sv
// Directed bench for ysyx_22041207_mul: latency, products, truncation, flush, reset and busy-time isolation.
module tb_ysyx_22041207_mul;

`ifdef YSYX_22041207_MUL_RADIX4_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif

    logic        clk;
    logic        rst;
    logic        mul_valid;
    logic        flush;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_ready;
    logic        out_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int          total;
    int          passed;
    int          pulses;
    logic [63:0] last;

    ysyx_22041207_mul dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
    task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                          input bit glitch, input string tag);
        int cyc;
        cyc          = 0;
        mul_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                mul_valid = 1'b0;
                chk({tag, "_busy_ready"}, {63'd0, mul_ready}, 64'd0);
            end
            if (n == 20) chk({tag, "_hold_mid"}, {result_hi, result_lo}, last);
            if (glitch && n == 5) begin
                mul_valid    = 1'b1;
                multiplicand = 64'd100;
                multiplier   = 64'd100;
            end
            if (glitch && n == 7) mul_valid = 1'b0;
            if (out_valid) begin
                cyc = n;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
        chk({tag, "_result"}, {result_hi, result_lo}, exp);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {62'd0, out_valid, mul_ready}, 64'd1);
        chk({tag, "_result_hold"}, {result_hi, result_lo}, exp);
        last = exp;
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        last         = 64'd0;
        rst          = 1'b1;
        mul_valid    = 1'b1;
        flush        = 1'b1;
        multiplicand = 64'd1;
        multiplier   = 64'd1;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        mul_valid = 1'b0;
        flush     = 1'b0;
        chk("reset_ready_valid", {62'd0, out_valid, mul_ready}, 64'd1);
        chk("reset_result", {result_hi, result_lo}, 64'd0);

        do_mul(64'd3, 64'd5, 64'h0000_0000_0000_000F, 1'b0, "3x5");
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "ones_x2");
        do_mul(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 1'b0, "trunc");
        do_mul(64'h1234_5678, 64'h10, 64'h0000_0001_2345_6780, 1'b0, "shift16");

        // Flush in IDLE blocks a simultaneous request.
        mul_valid    = 1'b1;
        flush        = 1'b1;
        multiplicand = 64'd4;
        multiplier   = 64'd4;
        @(negedge clk);
        mul_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_block", {63'd0, mul_ready}, 64'd1);

        // Flush at BUSY cycle 10 aborts with no pulse and keeps old result.
        mul_valid    = 1'b1;
        multiplicand = 64'd9;
        multiplier   = 64'd9;
        @(negedge clk);
        mul_valid = 1'b0;
        chk("flush_accepted", {63'd0, mul_ready}, 64'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_ready", {62'd0, out_valid, mul_ready}, 64'd1);
        chk("flush_busy_result", {result_hi, result_lo}, last);
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        chk("flush_no_pulse", 64'(pulses), 64'd0);

        do_mul(64'd7, 64'd6, 64'h2A, 1'b0, "7x6");
        do_mul(64'd2, 64'd3, 64'd6, 1'b1, "ignore_busy");

        // Reset mid-operation clears outputs and suppresses the pulse.
        mul_valid    = 1'b1;
        multiplicand = 64'd5;
        multiplier   = 64'd5;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready_valid", {62'd0, out_valid, mul_ready}, 64'd1);
        chk("rst_mid_result", {result_hi, result_lo}, 64'd0);
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        chk("rst_mid_no_pulse", 64'(pulses), 64'd0);
        last = 64'd0;

        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "signed_m1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
